// File: rtl/sb_tx_pkg.sv
// Shared constants and state encoding for the sideband TX framer/serializer.
package sb_tx_pkg;

  localparam int PKT_BITS = 64;
  localparam int GAP_BITS = 32;
  localparam int CNT_W    = 7;

  localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OPC_MSG_DATA   = 5'b11011;

  localparam logic [2:0] SRCID_RDI = 3'b001;
  localparam logic [2:0] SRCID_PHY = 3'b010;
  localparam logic [2:0] DSTID_RDI = 3'b101;
  localparam logic [2:0] DSTID_PHY = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HDR_GAP,
    ST_DATA,
    ST_DATA_GAP,
    ST_PAT,
    ST_PAT_GAP
  } sb_tx_state_e;

endpackage

// File: rtl/sb_tx_header_encoder.sv
// Combinational sideband message header builder, including data and control parity.
module sb_tx_header_encoder
  import sb_tx_pkg::*;
(
  input  logic [7:0]  msg_code,
  input  logic [7:0]  msg_subcode,
  input  logic [15:0] msg_info,
  input  logic        has_data,
  input  logic [63:0] data,
  input  logic        rdi_msg,
  output logic [63:0] header
);

  logic [63:0] hdr;

  // NOTE: every bit gets a value first so no path through this block can infer a latch.
  always_comb begin
    hdr        = '0;
    hdr[4:0]   = has_data ? OPC_MSG_DATA : OPC_MSG_NODATA;
    hdr[21:14] = msg_code;
    hdr[31:29] = rdi_msg ? SRCID_RDI : SRCID_PHY;
    hdr[39:32] = msg_subcode;
    hdr[55:40] = msg_info;
    hdr[58:56] = rdi_msg ? DSTID_RDI : DSTID_PHY;
    hdr[62]    = has_data & (^data);
    hdr[63]    = ^hdr[61:0];
  end

  assign header = hdr;

endmodule

// File: rtl/sb_tx_packet_serializer.sv
// Sideband TX framer: serializes header/data LSB-first with a 32-UI low gap, and
// generates the init clock pattern and the TXCKSB gate enable.
module sb_tx_packet_serializer
  import sb_tx_pkg::*;
#(
  parameter int PKT_BITS = sb_tx_pkg::PKT_BITS,
  parameter int GAP_BITS = sb_tx_pkg::GAP_BITS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_msg_valid,
  input  logic [7:0]  i_msg_code,
  input  logic [7:0]  i_msg_subcode,
  input  logic [15:0] i_msg_info,
  input  logic        i_has_data,
  input  logic [63:0] i_data,
  input  logic        i_rdi_msg,
  input  logic        i_pattern_req,
  output logic        o_ready,
  output logic        TXDATASB,
  output logic        o_clk_gate_en,
  output logic        o_packet_sent,
  output logic        o_pattern_done
);

  sb_tx_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      shreg_q, data_q, header;
  logic             has_data_q;
  logic             txd_q, txd_d, gate_q, gate_d;
  logic             load_hdr, load_data, shift_en;
  logic             last_pkt, last_gap;

  sb_tx_header_encoder u_hdr_enc (
    .msg_code    (i_msg_code),
    .msg_subcode (i_msg_subcode),
    .msg_info    (i_msg_info),
    .has_data    (i_has_data),
    .data        (i_data),
    .rdi_msg     (i_rdi_msg),
    .header      (header)
  );

  assign last_pkt = (cnt_q == CNT_W'(PKT_BITS - 1));
  assign last_gap = (cnt_q == CNT_W'(GAP_BITS - 1));

  // Each next-line value is decided one cycle ahead so TXDATASB and the gate are pure flops.
  always_comb begin
    state_d        = state_q;
    txd_d          = 1'b0;
    gate_d         = 1'b0;
    load_hdr       = 1'b0;
    load_data      = 1'b0;
    shift_en       = 1'b0;
    o_packet_sent  = 1'b0;
    o_pattern_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_pattern_req) begin
          state_d = ST_PAT;
          txd_d   = 1'b1;
          gate_d  = 1'b1;
        end else if (i_msg_valid) begin
          state_d  = ST_HDR;
          txd_d    = header[0];
          gate_d   = 1'b1;
          load_hdr = 1'b1;
        end
      end
      ST_HDR, ST_DATA: begin
        if (last_pkt) begin
          state_d = (state_q == ST_HDR) ? ST_HDR_GAP : ST_DATA_GAP;
        end else begin
          txd_d    = shreg_q[0];
          gate_d   = 1'b1;
          shift_en = 1'b1;
        end
      end
      ST_HDR_GAP: begin
        if (last_gap) begin
          if (has_data_q) begin
            state_d   = ST_DATA;
            txd_d     = data_q[0];
            gate_d    = 1'b1;
            load_data = 1'b1;
          end else begin
            state_d       = ST_IDLE;
            o_packet_sent = 1'b1;
          end
        end
      end
      ST_DATA_GAP: begin
        if (last_gap) begin
          state_d       = ST_IDLE;
          o_packet_sent = 1'b1;
        end
      end
      ST_PAT: begin
        if (last_pkt) begin
          state_d = ST_PAT_GAP;
        end else begin
          // Bit k is 1 for even k, so the bit after position cnt is cnt[0].
          txd_d  = cnt_q[0];
          gate_d = 1'b1;
        end
      end
      ST_PAT_GAP: begin
        if (last_gap) begin
          if (i_pattern_req) begin
            state_d = ST_PAT;
            txd_d   = 1'b1;
            gate_d  = 1'b1;
          end else begin
            state_d        = ST_IDLE;
            o_pattern_done = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      txd_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      gate_q  <= gate_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg_q    <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
    end else if (load_hdr) begin
      shreg_q    <= {1'b0, header[63:1]};
      data_q     <= i_data;
      has_data_q <= i_has_data;
    end else if (load_data) begin
      shreg_q <= {1'b0, data_q[63:1]};
    end else if (shift_en) begin
      shreg_q <= {1'b0, shreg_q[63:1]};
    end
  end

  assign o_ready       = (state_q == ST_IDLE);
  assign TXDATASB      = txd_q;
  assign o_clk_gate_en = gate_q;

endmodule

// File: tb/tb_sb_tx_packet_serializer.sv
// Directed self-checking bench for sb_tx_packet_serializer; all sampling and
// driving happens on the falling edge, mid-UI.
module tb_sb_tx_packet_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_msg_valid;
  logic [7:0]  i_msg_code;
  logic [7:0]  i_msg_subcode;
  logic [15:0] i_msg_info;
  logic        i_has_data;
  logic [63:0] i_data;
  logic        i_rdi_msg;
  logic        i_pattern_req;
  logic        o_ready;
  logic        TXDATASB;
  logic        o_clk_gate_en;
  logic        o_packet_sent;
  logic        o_pattern_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Hand-computed headers.
  // A: code A5, sub 1C, info 0003, no data, PHY -> 14 ones in [61:0], cp=0
  // B: code 01, sub 02, info 0000, data=1, RDI  -> dp=1, 9 ones in [61:0], cp=1
  // C: code FF, sub FF, info FFFF, no data, RDI -> 37 ones in [61:0], cp=1
  localparam logic [63:0] HDR_A    = 64'h0600_031C_4029_4012;
  localparam logic [63:0] HDR_B    = 64'hC500_0002_2000_401B;
  localparam logic [63:0] HDR_C    = 64'h85FF_FFFF_203F_C012;
  localparam logic [63:0] PAT_WORD = 64'h5555_5555_5555_5555;

  sb_tx_packet_serializer dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_msg_valid    (i_msg_valid),
    .i_msg_code     (i_msg_code),
    .i_msg_subcode  (i_msg_subcode),
    .i_msg_info     (i_msg_info),
    .i_has_data     (i_has_data),
    .i_data         (i_data),
    .i_rdi_msg      (i_rdi_msg),
    .i_pattern_req  (i_pattern_req),
    .o_ready        (o_ready),
    .TXDATASB       (TXDATASB),
    .o_clk_gate_en  (o_clk_gate_en),
    .o_packet_sent  (o_packet_sent),
    .o_pattern_done (o_pattern_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called mid-cycle; presents the request in the accept cycle T and returns mid T+1.
  task automatic drive_msg(input logic [7:0] code, input logic [7:0] sub, input logic [15:0] info,
                           input logic has, input logic [63:0] data, input logic rdi, input logic hold);
    int waited = 0;
    while (!o_ready && waited < 300) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) check("ready_timeout", 64'(o_ready), 64'd1);
    i_msg_code    = code;
    i_msg_subcode = sub;
    i_msg_info    = info;
    i_has_data    = has;
    i_data        = data;
    i_rdi_msg     = rdi;
    i_msg_valid   = 1'b1;
    @(negedge i_clk);
    if (!hold) i_msg_valid = 1'b0;
  endtask

  // Captures 64 consecutive line bits starting with the current UI.
  task automatic collect_frame(output logic [63:0] word, output int gate_n,
                               output int first_c, output int last_c, output int pulse_n);
    word    = '0;
    gate_n  = 0;
    pulse_n = 0;
    first_c = cyc;
    last_c  = cyc;
    for (int k = 0; k < 64; k++) begin
      word[k] = TXDATASB;
      gate_n += int'(o_clk_gate_en);
      pulse_n += int'(o_packet_sent) + int'(o_pattern_done);
      last_c  = cyc;
      @(negedge i_clk);
    end
  endtask

  // Observes the 32 gap UIs; pulse positions are 0-based within the gap.
  task automatic collect_gap(output int ones, output int gate_n, output int sent_n,
                             output int sent_pos, output int done_n, output int done_pos);
    ones = 0; gate_n = 0; sent_n = 0; sent_pos = -1; done_n = 0; done_pos = -1;
    for (int i = 0; i < 32; i++) begin
      ones   += int'(TXDATASB);
      gate_n += int'(o_clk_gate_en);
      if (o_packet_sent)  begin sent_n++; sent_pos = i; end
      if (o_pattern_done) begin done_n++; done_pos = i; end
      @(negedge i_clk);
    end
  endtask

  initial begin
    logic [63:0] word, exp_hdr;
    int gate_n, f1, l1, f2, l2, pulses;
    int ones, ggap, sent_n, sent_pos, done_n, done_pos;

    i_rst = 1'b1; i_msg_valid = 1'b0; i_msg_code = '0; i_msg_subcode = '0; i_msg_info = '0;
    i_has_data = 1'b0; i_data = '0; i_rdi_msg = 1'b0; i_pattern_req = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_txd", 64'(TXDATASB), 64'd0);
    check("rst_gate", 64'(o_clk_gate_en), 64'd0);
    check("rst_pulses", 64'({o_packet_sent, o_pattern_done}), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // 1: no-data PHY message
    drive_msg(8'hA5, 8'h1C, 16'h0003, 1'b0, 64'd0, 1'b0, 1'b0);
    collect_frame(word, gate_n, f1, l1, pulses);
    check("t1_header", word, HDR_A);
    check("t1_gate_hdr", 64'(gate_n), 64'd64);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t1_gap_low", 64'(ones), 64'd0);
    check("t1_gap_gate", 64'(ggap), 64'd0);
    check("t1_sent_count", 64'(sent_n), 64'd1);
    check("t1_sent_T96", 64'(sent_pos), 64'd31);
    check("t1_ready_T97", 64'(o_ready), 64'd1);

    // 2: data message from the RDI side
    drive_msg(8'h01, 8'h02, 16'h0000, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
    collect_frame(word, gate_n, f1, l1, pulses);
    check("t2_header", word, HDR_B);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t2_hgap_low_nogate", 64'(ones + ggap), 64'd0);
    check("t2_hgap_no_sent", 64'(sent_n), 64'd0);
    collect_frame(word, gate_n, f2, l2, pulses);
    check("t2_data", word, 64'd1);
    check("t2_data_gate", 64'(gate_n), 64'd64);
    check("t2_data_at_T97", 64'(f2 - f1), 64'd96);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t2_dgap_low_nogate", 64'(ones + ggap), 64'd0);
    check("t2_sent_T192", 64'(sent_pos), 64'd31);
    check("t2_sent_count", 64'(sent_n), 64'd1);

    // 3: valid held for two back-to-back messages; the second is accepted in the
    // UI after o_packet_sent, so bit0 lands one UI after that accept cycle.
    drive_msg(8'hFF, 8'hFF, 16'hFFFF, 1'b0, 64'd0, 1'b1, 1'b1);
    collect_frame(word, gate_n, f1, l1, pulses);
    check("t3_header1", word, HDR_C);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t3_sent1", 64'(sent_pos), 64'd31);
    check("t3_reaccept_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_msg_valid = 1'b0;
    collect_frame(word, gate_n, f2, l2, pulses);
    check("t3_header2", word, HDR_C);
    check("t3_spacing", 64'(f2 - l1), 64'd34);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t3_sent2", 64'(sent_pos), 64'd31);

    // 4: pattern wins over a simultaneous message; request dropped early in iteration 2
    i_msg_valid = 1'b1; i_has_data = 1'b0; i_pattern_req = 1'b1;
    @(negedge i_clk);
    check("t4_not_ready", 64'(o_ready), 64'd0);
    collect_frame(word, gate_n, f1, l1, pulses);
    check("t4_pat1", word, PAT_WORD);
    check("t4_pat1_gate", 64'(gate_n), 64'd64);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t4_gap1_low_nogate", 64'(ones + ggap), 64'd0);
    check("t4_gap1_no_done", 64'(done_n + sent_n), 64'd0);
    i_pattern_req = 1'b0;
    collect_frame(word, gate_n, f2, l2, pulses);
    check("t4_pat2", word, PAT_WORD);
    check("t4_pat2_start", 64'(f2 - f1), 64'd96);
    check("t4_pat_no_pulses", 64'(pulses), 64'd0);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t4_gap2_low_nogate", 64'(ones + ggap), 64'd0);
    check("t4_done_count", 64'(done_n), 64'd1);
    check("t4_done_last", 64'(done_pos), 64'd31);
    check("t4_no_sent", 64'(sent_n), 64'd0);
    check("t4_idle_ready", 64'(o_ready), 64'd1);
    i_msg_valid = 1'b0;
    @(negedge i_clk);

    // 5: asynchronous reset in the middle of header bit 20
    exp_hdr = HDR_C;
    drive_msg(8'hFF, 8'hFF, 16'hFFFF, 1'b0, 64'd0, 1'b1, 1'b0);
    repeat (20) @(negedge i_clk);
    check("t5_bit20_before", 64'(TXDATASB), 64'(exp_hdr[20]));
    check("t5_gate_before", 64'(o_clk_gate_en), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    check("t5_txd_async", 64'(TXDATASB), 64'd0);
    check("t5_gate_async", 64'(o_clk_gate_en), 64'd0);
    check("t5_ready_async", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("t5_ready_after", 64'(o_ready), 64'd1);
    drive_msg(8'hA5, 8'h1C, 16'h0003, 1'b0, 64'd0, 1'b0, 1'b0);
    collect_frame(word, gate_n, f1, l1, pulses);
    check("t5_header_clean", word, HDR_A);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t5_sent", 64'(sent_pos), 64'd31);

    // 6: pattern request raised during HDR waits for the message to finish
    drive_msg(8'hA5, 8'h1C, 16'h0003, 1'b0, 64'd0, 1'b0, 1'b0);
    i_pattern_req = 1'b1;
    collect_frame(word, gate_n, f1, l1, pulses);
    check("t6_header", word, HDR_A);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t6_gap_low", 64'(ones), 64'd0);
    check("t6_sent", 64'(sent_pos), 64'd31);
    check("t6_ready_T97", 64'(o_ready), 64'd1);
    check("t6_idle_line", 64'({TXDATASB, o_clk_gate_en}), 64'd0);
    @(negedge i_clk);
    check("t6_pat_start", 64'({TXDATASB, o_clk_gate_en}), 64'd3);
    i_pattern_req = 1'b0;
    collect_frame(word, gate_n, f2, l2, pulses);
    check("t6_pat", word, PAT_WORD);
    collect_gap(ones, ggap, sent_n, sent_pos, done_n, done_pos);
    check("t6_done", 64'(done_pos), 64'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
